pixel_stream_filter: RTL and testbench

//   Parametrised successor to the fixed 8-bit pixel processor. Takes a raster pixel

---
 rtl/pixel_stream_filter.sv | 210 +++++++++++++++++++++
 tb/tb_pixel_stream_filter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_filter.sv
// Streaming pixel filter: pass, invert, signed 3x3 convolution or threshold,
// with valid/ready backpressure, per-frame config latching and end-of-frame marking.
module pixel_stream_filter #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            mode,
    input  logic [9*COEF_W-1:0]   kernel,
    input  logic [3:0]            norm_shift,
    input  logic [PIX_W-1:0]      thresh,
    input  logic                  s_valid,
    input  logic [PIX_W-1:0]      s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [PIX_W-1:0]      m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
);
    localparam int SUM_W = PIX_W + COEF_W + 5;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    // raster position of the next pixel to be accepted
    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;

    // configuration held for the current frame
    logic [1:0]             r_mode;
    logic [9*COEF_W-1:0]    r_kernel;
    logic [3:0]             r_shift;
    logic [PIX_W-1:0]       r_thresh;

    // stage 1: raw pixel / convolution sum plus the config needed to finish it
    logic                   r_s1_valid;
    logic                   r_s1_last;
    logic [1:0]             r_s1_mode;
    logic [PIX_W-1:0]       r_s1_pix;
    logic [PIX_W-1:0]       r_s1_thresh;
    logic [3:0]             r_s1_shift;
    logic signed [SUM_W-1:0] r_s1_sum;

    // two previous lines and the two previous columns of the 3x3 window
    logic [PIX_W-1:0]       r_lb0 [IMG_W];   // line r-1
    logic [PIX_W-1:0]       r_lb1 [IMG_W];   // line r-2
    logic [PIX_W-1:0]       r_win [3][2];    // [row][col], col 0 = oldest

    logic                   w_accept;
    logic                   w_s2_adv;
    logic                   w_first;
    logic                   w_col_last;
    logic                   w_row_last;
    logic                   w_produce;
    logic                   w_last;
    logic [1:0]             w_mode;
    logic [9*COEF_W-1:0]    w_kernel;
    logic [3:0]             w_shift;
    logic [PIX_W-1:0]       w_thresh;
    logic [PIX_W-1:0]       w_col_new [3];
    logic signed [SUM_W-1:0] w_prod [9];
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shifted;
    logic [PIX_W-1:0]       w_sat;
    logic [PIX_W-1:0]       w_out;

    assign w_s2_adv   = !m_valid || m_ready;
    assign s_ready    = !r_s1_valid || w_s2_adv;
    assign w_accept   = s_valid && s_ready;
    assign busy       = (r_col != '0) || (r_row != '0);
    assign w_first    = (r_col == '0) && (r_row == '0);
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_last     = w_col_last && w_row_last;

    // pixel (0,0) already uses the incoming config; the rest of the frame uses the latched copy
    assign w_mode     = w_first ? mode       : r_mode;
    assign w_kernel   = w_first ? kernel     : r_kernel;
    assign w_shift    = w_first ? norm_shift : r_shift;
    assign w_thresh   = w_first ? thresh     : r_thresh;

    // convolution emits only once a full window lies inside the current frame
    assign w_produce  = (w_mode != 2'b10) || ((r_row >= RW'(2)) && (r_col >= CW'(2)));

    // newest window column: top from line r-2, middle from line r-1, bottom is the live pixel
    assign w_col_new[0] = r_lb1[r_col];
    assign w_col_new[1] = r_lb0[r_col];
    assign w_col_new[2] = s_data;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            localparam int WR = gi / 3;
            localparam int WC = gi % 3;
            logic [PIX_W-1:0]  w_pix;
            logic [COEF_W-1:0] w_coef;
            if (WC == 2) begin : g_new
                assign w_pix = w_col_new[WR];
            end else begin : g_reg
                assign w_pix = r_win[WR][WC];
            end
            assign w_coef     = w_kernel[gi*COEF_W +: COEF_W];
            assign w_prod[gi] = $signed({{(SUM_W-PIX_W){1'b0}}, w_pix})
                              * $signed({{(SUM_W-COEF_W){w_coef[COEF_W-1]}}, w_coef});
        end
    endgenerate

    // sum of the nine products; the width leaves headroom so it cannot overflow
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + w_prod[k];
        end
    end

    // normalise and clamp the stage-1 sum, then pick the result for the frame's mode
    always_comb begin
        w_shifted = r_s1_sum >>> r_s1_shift;
        w_sat     = w_shifted[PIX_W-1:0];
        if (w_shifted[SUM_W-1]) begin
            w_sat = '0;
        end else if (|w_shifted[SUM_W-2:PIX_W]) begin
            w_sat = '1;
        end
        case (r_s1_mode)
            2'b00:   w_out = r_s1_pix;
            2'b01:   w_out = ~r_s1_pix;
            2'b10:   w_out = w_sat;
            default: w_out = (r_s1_pix >= r_s1_thresh) ? '1 : '0;
        endcase
    end

    // raster counters and frame-aligned config capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col    <= '0;
            r_row    <= '0;
            r_mode   <= '0;
            r_kernel <= '0;
            r_shift  <= '0;
            r_thresh <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_mode   <= mode;
                r_kernel <= kernel;
                r_shift  <= norm_shift;
                r_thresh <= thresh;
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // line buffers and window columns; contents need no reset because windows never span frames
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= s_data;
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_col_new[r];
            end
        end
    end

    // stage 1: loads whenever it can move on; beats that produce no output leave it empty
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_mode   <= '0;
            r_s1_pix    <= '0;
            r_s1_thresh <= '0;
            r_s1_shift  <= '0;
            r_s1_sum    <= '0;
        end else if (s_ready) begin
            r_s1_valid <= w_accept && w_produce;
            if (w_accept) begin
                r_s1_last   <= w_last;
                r_s1_mode   <= w_mode;
                r_s1_pix    <= s_data;
                r_s1_thresh <= w_thresh;
                r_s1_shift  <= w_shift;
                r_s1_sum    <= w_sum;
            end
        end
    end

    // stage 2: output register, frozen while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (w_s2_adv) begin
            m_valid <= r_s1_valid;
            m_last  <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                m_data <= w_out;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_filter.sv
// Self-checking bench for pixel_stream_filter on an 8x6 frame.
module tb_pixel_stream_filter;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [71:0] kernel = '0;
    logic [3:0]  norm_shift = '0;
    logic [7:0]  thresh = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit lat_en = 1'b0;
    bit rnd_ready = 1'b0;
    bit gaps = 1'b0;
    logic [8:0] exp_q[$];
    int acc_q[$];
    int frame_pix[N];

    bit stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;
    logic [8:0] e_mon;

    pixel_stream_filter #(.PIX_W(8), .COEF_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .kernel(kernel), .norm_shift(norm_shift),
        .thresh(thresh), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // output monitor: scoreboard compare on every transfer, hold check on every stall
    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
                chk("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (lat_en && s_valid && s_ready) acc_q.push_back(cyc);
            if (m_valid && m_ready) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL extra_out: observed %0h expected no output", m_data);
                end
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    $display("out data=%02h last=%0d exp=%02h/%0d", m_data, m_last, e_mon[7:0], e_mon[8]);
                    chk("out_data", 32'(m_data), 32'(e_mon[7:0]));
                    chk("out_last", 32'(m_last), 32'(e_mon[8]));
                end
                if (lat_en && acc_q.size() != 0) chk("latency", 32'(cyc), 32'(acc_q.pop_front() + 2));
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // reference: expected outputs of one whole frame from frame_pix
    task automatic model(input int md, input logic [71:0] kern, input int sh, input int th);
        int v, d, s;
        logic [7:0] cb;
        if (md != 2) begin
            for (int i = 0; i < N; i++) begin
                v = frame_pix[i];
                if (md == 0) d = v;
                else if (md == 1) d = 255 - v;
                else d = (v >= th) ? 255 : 0;
                exp_q.push_back({(i == N - 1), 8'(d)});
            end
        end else begin
            for (int r = 1; r <= H - 2; r++) begin
                for (int c = 1; c <= W - 2; c++) begin
                    s = 0;
                    for (int dr = 0; dr < 3; dr++) begin
                        for (int dc = 0; dc < 3; dc++) begin
                            cb = kern[(dr * 3 + dc) * 8 +: 8];
                            s += int'($signed(cb)) * frame_pix[(r - 1 + dr) * W + (c - 1 + dc)];
                        end
                    end
                    s = s >>> sh;
                    if (s < 0) s = 0;
                    if (s > 255) s = 255;
                    exp_q.push_back({(r == H - 2 && c == W - 2), 8'(s)});
                end
            end
        end
    endtask

    task automatic send_pix(input logic [7:0] d);
        bit acc = 1'b0;
        int g = 0;
        if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        s_data  = d;
        s_valid = 1'b1;
        while (!acc && g < 500) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            g++;
        end
        s_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic run_frame(input int md, input logic [71:0] kern, input int sh, input int th);
        mode = 2'(md);
        kernel = kern;
        norm_shift = 4'(sh);
        thresh = 8'(th);
        model(md, kern, sh, th);
        for (int i = 0; i < N; i++) send_pix(8'(frame_pix[i]));
    endtask

    task automatic drain(input bit idle_expected);
        int g = 0;
        while (exp_q.size() != 0 && g < 2000) begin @(posedge clk); #1; g++; end
        repeat (3) begin @(posedge clk); #1; end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        if (idle_expected) chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < N; i++) frame_pix[i] = v;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) frame_pix[i] = i;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [71:0] rk;
        int md;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // pass mode on the ramp with latency tracking
        fill_ramp();
        lat_en = 1'b1;
        run_frame(0, '0, 0, 0);
        drain(1'b1);
        lat_en = 1'b0;
        chk("latency_all_seen", 32'(acc_q.size()), 32'd0);

        // invert and threshold on the four corner values
        for (int i = 0; i < N; i++) begin
            case (i % 4)
                0: frame_pix[i] = 8'h00;
                1: frame_pix[i] = 8'h7F;
                2: frame_pix[i] = 8'h80;
                default: frame_pix[i] = 8'hFF;
            endcase
        end
        run_frame(1, '0, 0, 0);
        drain(1'b1);
        run_frame(3, '0, 0, 8'h80);
        drain(1'b1);

        // box filter, normal and saturating
        fill_const(80);
        run_frame(2, {9{8'h01}}, 3, 0);
        drain(1'b1);
        fill_const(255);
        run_frame(2, {9{8'h01}}, 3, 0);
        drain(1'b1);

        // negative clamp and identity kernel on the ramp
        fill_ramp();
        run_frame(2, 72'hFF << 32, 0, 0);
        drain(1'b1);
        run_frame(2, 72'h01 << 32, 0, 0);
        drain(1'b1);

        // random data, config, gaps and backpressure over three frames
        rnd_ready = 1'b1;
        gaps = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) frame_pix[i] = int'($urandom_range(0, 255));
            for (int b = 0; b < 9; b++) rk[b * 8 +: 8] = 8'($urandom_range(0, 255));
            md = (f == 1) ? int'($urandom_range(0, 3)) : 2;
            run_frame(md, rk, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end
        drain(1'b1);
        rnd_ready = 1'b0;
        gaps = 1'b0;

        // mid-frame mode change is ignored; reset then restarts in the new mode
        fill_ramp();
        mode = 2'b00;
        for (int i = 0; i < 30; i++) exp_q.push_back({1'b0, 8'(frame_pix[i])});
        for (int i = 0; i < 20; i++) send_pix(8'(frame_pix[i]));
        mode = 2'b01;
        for (int i = 20; i < 30; i++) send_pix(8'(frame_pix[i]));
        drain(1'b0);
        chk("busy_mid", 32'(busy), 32'd1);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        run_frame(1, '0, 0, 0);
        drain(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
